// File: rtl/sync_pkt_fifo.sv
// sync_pkt_fifo: single-clock frame-aware FIFO with speculative write pointer, commit/rewind and overflow discard.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   w_en/w_data/w_last     write beat strobe, data, end-of-frame flag
//   w_drop                 abort the frame being written (qualified by w_en)
//   w_full/w_afull         no free entry / free entries <= AFULL_MARGIN
//   w_ovf_drop             one-cycle pulse after a frame is discarded for overflow
//   drop_cnt               saturating count of discarded frames
//   r_en                   read strobe
//   r_data/r_last/r_valid  registered read beat, its end-of-frame flag, update flag
//   r_empty                no committed beat available
//   frame_cnt/fill_cnt     complete frames stored / entries in use incl. uncommitted
module sync_pkt_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 6,
    parameter int AFULL_MARGIN = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  w_last,
    input  logic                  w_drop,
    output logic                  w_full,
    output logic                  w_afull,
    output logic                  w_ovf_drop,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_last,
    output logic                  r_valid,
    output logic                  r_empty,
    output logic [ADDR_WIDTH:0]   frame_cnt,
    output logic [ADDR_WIDTH:0]   fill_cnt
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_V  = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] MARGIN_V = AFULL_MARGIN[ADDR_WIDTH:0];
    typedef enum logic {PASS = 1'b0, DISCARD = 1'b1} state_e;
    logic [DATA_WIDTH:0]   mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wp_spec_q, wp_spec_d, wp_com_q, wp_com_d, rp_q, frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic                  r_last_q, r_valid_q, ovf_pulse_q, ovf_pulse_d;
    state_e                state_q, state_d;
    logic                  we, commit, drop_inc, rd, rd_last;
    logic [DATA_WIDTH:0]   rd_word;
    assign fill_cnt   = wp_spec_q - rp_q;
    assign w_full     = fill_cnt == DEPTH_V;
    assign w_afull    = (DEPTH_V - fill_cnt) <= MARGIN_V;
    assign r_empty    = rp_q == wp_com_q;
    assign w_ovf_drop = ovf_pulse_q;
    assign drop_cnt   = drop_cnt_q;
    assign frame_cnt  = frame_cnt_q;
    assign r_data     = r_data_q;
    assign r_last     = r_last_q;
    assign r_valid    = r_valid_q;
    assign rd         = r_en && !r_empty;
    assign rd_word    = mem_q[rp_q[ADDR_WIDTH-1:0]];
    assign rd_last    = rd && rd_word[DATA_WIDTH];
    // Write FSM: any rewind returns wp_spec to the committed end, discarding the partial frame.
    always_comb begin
        wp_spec_d   = wp_spec_q;
        wp_com_d    = wp_com_q;
        state_d     = state_q;
        drop_inc    = 1'b0;
        ovf_pulse_d = 1'b0;
        we          = 1'b0;
        commit      = 1'b0;
        if (w_en) begin
            if (w_drop) begin
                wp_spec_d = wp_com_q;
                state_d   = PASS;
                drop_inc  = 1'b1;
            end else if (state_q == DISCARD) begin
                if (w_last) begin
                    wp_spec_d   = wp_com_q;
                    state_d     = PASS;
                    ovf_pulse_d = 1'b1;
                    drop_inc    = 1'b1;
                end
            end else if (w_full) begin
                if (w_last) begin
                    wp_spec_d   = wp_com_q;
                    ovf_pulse_d = 1'b1;
                    drop_inc    = 1'b1;
                end else begin
                    state_d = DISCARD;
                end
            end else begin
                we        = 1'b1;
                wp_spec_d = wp_spec_q + 1'b1;
                commit    = w_last;
                wp_com_d  = w_last ? wp_spec_q + 1'b1 : wp_com_q;
            end
        end
        drop_cnt_d  = (drop_inc && !(&drop_cnt_q)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
        // A same-cycle commit and last-beat read cancel out.
        frame_cnt_d = frame_cnt_q + {{ADDR_WIDTH{1'b0}}, commit} - {{ADDR_WIDTH{1'b0}}, rd_last};
    end
    always_ff @(posedge clk) begin
        if (we) mem_q[wp_spec_q[ADDR_WIDTH-1:0]] <= {w_last, w_data};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_spec_q   <= '0;
            wp_com_q    <= '0;
            rp_q        <= '0;
            state_q     <= PASS;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            ovf_pulse_q <= 1'b0;
            r_data_q    <= '0;
            r_last_q    <= 1'b0;
            r_valid_q   <= 1'b0;
        end else begin
            wp_spec_q   <= wp_spec_d;
            wp_com_q    <= wp_com_d;
            rp_q        <= rd ? rp_q + 1'b1 : rp_q;
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            ovf_pulse_q <= ovf_pulse_d;
            r_valid_q   <= rd;
            if (rd) {r_last_q, r_data_q} <= rd_word;
        end
    end
endmodule

// File: tb/tb_sync_pkt_fifo.sv
// tb_sync_pkt_fifo: scenario-task bench for sync_pkt_fifo (depth 8) with a beat scoreboard.
module tb_sync_pkt_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       w_en = 1'b0, w_last = 1'b0, w_drop = 1'b0, r_en = 1'b0;
    logic [7:0] w_data = '0;
    logic       w_full, w_afull, w_ovf_drop, r_last, r_valid, r_empty;
    logic [15:0] drop_cnt;
    logic [7:0] r_data;
    logic [3:0] frame_cnt, fill_cnt;
    int checks = 0;
    int errors = 0;
    logic [8:0] sb [$];
    logic [8:0] pend [$];

    sync_pkt_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AFULL_MARGIN(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_data(w_data), .w_last(w_last), .w_drop(w_drop),
        .w_full(w_full), .w_afull(w_afull), .w_ovf_drop(w_ovf_drop), .drop_cnt(drop_cnt),
        .r_en(r_en), .r_data(r_data), .r_last(r_last), .r_valid(r_valid), .r_empty(r_empty),
        .frame_cnt(frame_cnt), .fill_cnt(fill_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change right after a falling edge; outputs are sampled at the next falling edge.
    task automatic step(input logic we, input logic [7:0] d, input logic l, input logic dr, input logic re);
        w_en = we; w_data = d; w_last = l; w_drop = dr; r_en = re;
        @(negedge clk);
        w_en = 0; w_data = '0; w_last = 0; w_drop = 0; r_en = 0;
    endtask

    task automatic push_beat(input logic [7:0] d, input logic l);
        pend.push_back({l, d});
        if (l) begin
            foreach (pend[i]) sb.push_back(pend[i]);
            pend.delete();
        end
    endtask

    task automatic wr(input logic [7:0] d, input logic l);
        step(1'b1, d, l, 1'b0, 1'b0);
        push_beat(d, l);
    endtask

    task automatic rd_chk(input string nm);
        logic [8:0] e;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (sb.size() == 0) begin
            errors++; $display("FAIL %s scoreboard empty, got %0h", nm, {r_last, r_data});
        end else begin
            e = sb.pop_front();
            if (r_valid !== 1'b1 || {r_last, r_data} !== e) begin
                errors++; $display("FAIL %s got valid=%0b beat=%0h exp valid=1 beat=%0h", nm, r_valid, {r_last, r_data}, e);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({r_empty, w_full, w_afull, w_ovf_drop, r_valid, r_last} !== 6'b100000) begin
            errors++; $display("FAIL reset_flags got %b exp 100000", {r_empty, w_full, w_afull, w_ovf_drop, r_valid, r_last});
        end
        checks++;
        if (fill_cnt !== 4'd0 || frame_cnt !== 4'd0 || drop_cnt !== 16'd0 || r_data !== 8'd0) begin
            errors++; $display("FAIL reset_counts got fill=%0d frame=%0d drop=%0d data=%0h exp 0", fill_cnt, frame_cnt, drop_cnt, r_data);
        end
        rst_n = 1'b1;
        sb.delete();
        pend.delete();
        @(negedge clk);
    endtask

    task automatic test_basic;
        wr(8'hA1, 0); wr(8'hA2, 0); wr(8'hA3, 1);
        checks++;
        if (frame_cnt !== 4'd1 || r_empty !== 1'b0 || w_afull !== 1'b0) begin
            errors++; $display("FAIL basic_commit got frame=%0d empty=%0b afull=%0b exp 1 0 0", frame_cnt, r_empty, w_afull);
        end
        rd_chk("basic_rd0"); rd_chk("basic_rd1"); rd_chk("basic_rd2");
        checks++;
        if (r_empty !== 1'b1 || frame_cnt !== 4'd0 || fill_cnt !== 4'd0) begin
            errors++; $display("FAIL basic_after got empty=%0b frame=%0d fill=%0d exp 1 0 0", r_empty, frame_cnt, fill_cnt);
        end
    endtask

    task automatic test_early_read;
        wr(8'hB1, 0); wr(8'hB2, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (r_empty !== 1'b1 || r_valid !== 1'b0 || fill_cnt !== 4'd2) begin
            errors++; $display("FAIL early_blocked got empty=%0b valid=%0b fill=%0d exp 1 0 2", r_empty, r_valid, fill_cnt);
        end
        wr(8'hB3, 1);
        checks++;
        if (r_empty !== 1'b0 || frame_cnt !== 4'd1) begin
            errors++; $display("FAIL early_commit got empty=%0b frame=%0d exp 0 1", r_empty, frame_cnt);
        end
        rd_chk("early_rd0"); rd_chk("early_rd1"); rd_chk("early_rd2");
    endtask

    task automatic test_drop;
        wr(8'h11, 0); wr(8'h12, 1); wr(8'h20, 0); wr(8'h21, 0);
        checks++;
        if (fill_cnt !== 4'd4) begin
            errors++; $display("FAIL drop_pre_fill got %0d exp 4", fill_cnt);
        end
        step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        pend.delete();
        checks++;
        if (fill_cnt !== 4'd2 || drop_cnt !== 16'd1 || w_ovf_drop !== 1'b0) begin
            errors++; $display("FAIL drop_rewind got fill=%0d drop=%0d ovf=%0b exp 2 1 0", fill_cnt, drop_cnt, w_ovf_drop);
        end
        rd_chk("drop_rd0"); rd_chk("drop_rd1");
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (r_empty !== 1'b1 || r_valid !== 1'b0 || {r_last, r_data} !== 9'h112) begin
            errors++; $display("FAIL drop_empty got empty=%0b valid=%0b beat=%0h exp 1 0 112", r_empty, r_valid, {r_last, r_data});
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 5; i++) wr(8'h30 + 8'(i), i == 4);
        checks++;
        if (fill_cnt !== 4'd5 || w_afull !== 1'b1 || w_full !== 1'b0) begin
            errors++; $display("FAIL ovf_first got fill=%0d afull=%0b full=%0b exp 5 1 0", fill_cnt, w_afull, w_full);
        end
        for (int i = 0; i < 3; i++) wr(8'h50 + 8'(i), 0);
        checks++;
        if (w_full !== 1'b1 || fill_cnt !== 4'd8) begin
            errors++; $display("FAIL ovf_full got full=%0b fill=%0d exp 1 8", w_full, fill_cnt);
        end
        for (int i = 3; i < 5; i++) begin
            step(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0);
            checks++;
            if (w_ovf_drop !== 1'b0) begin
                errors++; $display("FAIL ovf_early_pulse got %0b exp 0", w_ovf_drop);
            end
        end
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        pend.delete();
        checks++;
        if (w_ovf_drop !== 1'b1 || drop_cnt !== 16'd1 || fill_cnt !== 4'd5) begin
            errors++; $display("FAIL ovf_pulse got ovf=%0b drop=%0d fill=%0d exp 1 1 5", w_ovf_drop, drop_cnt, fill_cnt);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (w_ovf_drop !== 1'b0) begin
            errors++; $display("FAIL ovf_pulse_width got %0b exp 0", w_ovf_drop);
        end
        wr(8'h60, 0); wr(8'h61, 1);
        checks++;
        if (frame_cnt !== 4'd2 || fill_cnt !== 4'd7) begin
            errors++; $display("FAIL ovf_next_frame got frame=%0d fill=%0d exp 2 7", frame_cnt, fill_cnt);
        end
        for (int i = 0; i < 7; i++) rd_chk("ovf_drain");
    endtask

    task automatic test_back_to_back;
        int sent = 0, len = 0, idx = 0, cyc = 0, lasts, occ;
        logic in_frame = 1'b0;
        logic re, rexp, we, l;
        logic [7:0] d;
        logic [8:0] e;
        while (sent < 40 || sb.size() != 0 || in_frame) begin
            if (cyc++ > 3000) begin
                errors++; $display("FAIL b2b_timeout sent=%0d left=%0d", sent, sb.size());
                break;
            end
            occ = sb.size() + pend.size();
            re = 1'($urandom_range(0, 1));
            rexp = re && sb.size() != 0;
            e = '0;
            if (rexp) e = sb.pop_front();
            if (!in_frame && sent < 40) begin
                len = $urandom_range(1, 4);
                idx = 0;
                in_frame = (occ + len <= 8) && ($urandom_range(0, 3) != 0);
            end
            we = in_frame;
            d = 8'($urandom);
            l = in_frame && idx == len - 1;
            if (we) begin
                push_beat(d, l);
                idx++;
                if (l) begin in_frame = 1'b0; sent++; end
            end
            step(we, d, l, 1'b0, re);
            checks++;
            if (r_valid !== rexp || (rexp && {r_last, r_data} !== e)) begin
                errors++; $display("FAIL b2b_read got valid=%0b beat=%0h exp valid=%0b beat=%0h", r_valid, {r_last, r_data}, rexp, e);
            end
            lasts = 0;
            foreach (sb[i]) lasts += int'(sb[i][8]);
            checks++;
            if (frame_cnt !== 4'(lasts) || fill_cnt !== 4'(sb.size() + pend.size())) begin
                errors++; $display("FAIL b2b_counts got frame=%0d fill=%0d exp %0d %0d", frame_cnt, fill_cnt, lasts, sb.size() + pend.size());
            end
        end
    endtask

    task automatic test_async_reset;
        wr(8'h55, 0); wr(8'h56, 1); wr(8'h57, 0);
        rd_chk("ar_rd");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (r_valid !== 1'b0 || r_data !== 8'd0 || r_empty !== 1'b1 || fill_cnt !== 4'd0 || frame_cnt !== 4'd0 || drop_cnt !== 16'd0) begin
            errors++; $display("FAIL async_reset got valid=%0b data=%0h empty=%0b fill=%0d frame=%0d drop=%0d", r_valid, r_data, r_empty, fill_cnt, frame_cnt, drop_cnt);
        end
        sb.delete();
        pend.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr(8'h77, 1);
        rd_chk("ar_after");
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_reset;
        test_early_read;
        test_reset;
        test_drop;
        test_reset;
        test_overflow;
        test_reset;
        test_back_to_back;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
